// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared widths for the RAM-backed stream FIFO controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_fifo_ctrl_pkg;

  localparam int AW_DEF    = 10;  // RAM address width, depth 2^AW
  localparam int DW_DEF    = 64;  // data word width
  localparam int BUF_DEPTH = 2;   // prefetch/output buffer entries

  // Read/write pointers carry one extra wrap bit above the RAM address.
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Producer and consumer valid/ready streams of the RAM FIFO controller.
// Latency: n/a (wires only).
// Backpressure: in_ready throttles the producer, out_ready throttles the FIFO.
// Ports: in_valid/in_data/in_ready (write side), out_valid/out_data/out_ready (read side).
interface ram_fifo_ctrl_if #(
  parameter int DW = ram_fifo_ctrl_pkg::DW_DEF
);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  // slave: the FIFO controller itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // master: the producer/consumer environment around the FIFO
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// 2-entry output buffer fed by RAM read data; head entry drives out_data directly.
// Latency: a push into an empty buffer is visible on out_valid/out_data next cycle.
// Backpressure: caller must never push when full unless popping in the same cycle.
// Ports: push/push_dat (from RAM), pop (consumer accept), buf_cnt, out_valid, out_data.
module fifo_skid_buf
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [1:0]    buf_cnt,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;

  always_comb begin
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    head_d = head_q;
    tail_d = tail_q;
    if (pop) begin
      if (cnt_q == DEPTH) begin
        // tail advances to head; a simultaneous push refills the tail
        head_d = tail_q;
        if (push) tail_d = push_dat;
      end else if (push) begin
        head_d = push_dat;
      end
    end else if (push) begin
      if (cnt_q == 2'd0) head_d = push_dat;
      else               tail_d = push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign buf_cnt   = cnt_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO around a 2^AW x DW simple dual-port RAM with 1-cycle registered reads.
// Latency: 3 cycles from input accept to out_valid on an empty FIFO; 1 word/cycle sustained.
// Backpressure: in_ready drops only when the RAM is full; reads prefetch into a 2-entry buffer.
// Ports: clk, rst (sync, active-low), bus (streams), level, ram_raddr/ram_rd, ram_waddr/ram_wr/ram_we.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  ram_fifo_ctrl_if.slave bus,
  output logic [AW:0]   level,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rd,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wr,
  output logic          ram_we
);

  localparam int             PW       = ptr_w(AW);
  localparam logic [PW-1:0]  FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          rd_pend_q, rd_pend_d;
  logic [AW:0]   level_q, level_d;

  logic [PW-1:0] ram_cnt;
  logic          in_rdy;
  logic          wr_xfer;
  logic          pop;
  logic          issue;
  logic [2:0]    buf_need;
  logic [1:0]    buf_cnt;
  logic          out_vld;
  logic [DW-1:0] out_dat;

  // in_ready comes only from registered pointers, never from out_ready
  assign ram_cnt = wptr_q - rptr_q;
  assign in_rdy  = rst & (ram_cnt != FULL_CNT);
  assign wr_xfer = bus.in_valid & in_rdy;
  assign pop     = out_vld & bus.out_ready;

  // Buffer slots committed after this cycle: held + in flight - leaving.
  // Issuing only below 2 guarantees the buffer never overflows.
  assign buf_need = {1'b0, buf_cnt} + {2'b0, rd_pend_q} - {2'b0, pop};
  assign issue    = (ram_cnt != '0) && (buf_need < 3'd2);

  always_comb begin
    wptr_d    = wptr_q + {{AW{1'b0}}, wr_xfer};
    rptr_d    = rptr_q + {{AW{1'b0}}, issue};
    rd_pend_d = issue;
    // Issue and push only move words between RAM, flight and buffer,
    // so the total changes only on accept and pop.
    level_d   = level_q + {{AW{1'b0}}, wr_xfer} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      rd_pend_q <= 1'b0;
      level_q   <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rd_pend_q <= rd_pend_d;
      level_q   <= level_d;
    end
  end

  fifo_skid_buf #(
    .DW (DW)
  ) u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend_q),
    .push_dat  (ram_rd),
    .pop       (pop),
    .buf_cnt   (buf_cnt),
    .out_valid (out_vld),
    .out_data  (out_dat)
  );

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = out_dat;

  assign ram_we    = wr_xfer;
  assign ram_waddr = wptr_q[AW-1:0];
  assign ram_wr    = bus.in_data;
  assign ram_raddr = rptr_q[AW-1:0];
  assign level     = level_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
module tb_ram_fifo_ctrl;
  import ram_fifo_ctrl_pkg::*;

  localparam int AW = 10;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic [AW:0]   level;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [DW-1:0] ram_rd, ram_wr;
  logic          ram_we;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks   = 0;
  int failures = 0;

  ram_fifo_ctrl_if #(.DW(DW)) bus();

  ram_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .level     (level),
    .ram_raddr (ram_raddr),
    .ram_rd    (ram_rd),
    .ram_waddr (ram_waddr),
    .ram_wr    (ram_wr),
    .ram_we    (ram_we)
  );

  // RAM model: registered read, read-before-write
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wr;
    ram_rd <= mem[ram_raddr];
  end

  // Drive one cycle's inputs at the falling edge and let them settle.
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic r);
    @(negedge clk);
    rst = r; bus.in_valid = iv; bus.in_data = id; bus.out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 64'h55, 1'b0, 1'b0);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_ram_we got=%0b exp=0", ram_we); end
    step(1'b0, 64'h0, 1'b0, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (level !== 11'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", level); end
    checks++; if (bus.out_data !== 64'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0", bus.out_data); end
    checks++; if (ram_raddr !== 10'd0 || ram_waddr !== 10'd0) begin failures++; $display("FAIL rst_addrs got=%0d/%0d exp=0/0", ram_raddr, ram_waddr); end
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = 64'h0123_4567_89AB_CDEF;
    step(1'b1, d, 1'b0, 1'b1);  // cycle 0
    checks++; if (ram_we !== 1'b1 || ram_waddr !== 10'd0 || ram_wr !== d) begin failures++; $display("FAIL single_write got we=%0b addr=%0d dat=%h exp we=1 addr=0 dat=%h", ram_we, ram_waddr, ram_wr, d); end
    step(1'b0, 64'h0, 1'b0, 1'b1);  // cycle 1
    checks++; if (level !== 11'd1) begin failures++; $display("FAIL single_level_c1 got=%0d exp=1", level); end
    checks++; if (bus.out_valid !== 1'b0 || ram_raddr !== 10'd0) begin failures++; $display("FAIL single_c1 got valid=%0b raddr=%0d exp valid=0 raddr=0", bus.out_valid, ram_raddr); end
    step(1'b0, 64'h0, 1'b0, 1'b1);  // cycle 2
    checks++; if (bus.out_valid !== 1'b0 || level !== 11'd1) begin failures++; $display("FAIL single_c2 got valid=%0b level=%0d exp valid=0 level=1", bus.out_valid, level); end
    step(1'b0, 64'h0, 1'b0, 1'b1);  // cycle 3
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== d) begin failures++; $display("FAIL single_c3 got valid=%0b dat=%h exp valid=1 dat=%h", bus.out_valid, bus.out_data, d); end
    checks++; if (level !== 11'd1) begin failures++; $display("FAIL single_level_c3 got=%0d exp=1", level); end
    step(1'b0, 64'h0, 1'b0, 1'b1);  // held without pop
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== d) begin failures++; $display("FAIL single_hold got valid=%0b dat=%h exp valid=1 dat=%h", bus.out_valid, bus.out_data, d); end
    step(1'b0, 64'h0, 1'b1, 1'b1);  // pop
    step(1'b0, 64'h0, 1'b0, 1'b1);
    checks++; if (bus.out_valid !== 1'b0 || level !== 11'd0) begin failures++; $display("FAIL single_after_pop got valid=%0b level=%0d exp valid=0 level=0", bus.out_valid, level); end
  endtask

  task automatic test_stream();
    int sent = 0, got = 0, wraps = 0, bubbles = 0, bad = 0;
    logic started = 1'b0;
    logic [AW-1:0] prev_raddr;
    prev_raddr = ram_raddr;
    for (int c = 0; c < 4300 && got < 4096; c++) begin
      step(sent < 4096, 64'(sent), 1'b1, 1'b1);
      if (prev_raddr == 10'd1023 && ram_raddr == 10'd0) wraps++;
      prev_raddr = ram_raddr;
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid) begin
        if (bus.out_data !== 64'(got)) begin
          if (bad == 0) $display("stream first bad word: got=%h exp=%h", bus.out_data, 64'(got));
          bad++;
        end
        got++;
        started = 1'b1;
      end else if (started) begin
        bubbles++;
      end
    end
    checks++; if (got != 4096) begin failures++; $display("FAIL stream_count got=%0d exp=4096", got); end
    checks++; if (bad != 0) begin failures++; $display("FAIL stream_data bad_words=%0d exp=0", bad); end
    checks++; if (bubbles != 0) begin failures++; $display("FAIL stream_bubbles got=%0d exp=0", bubbles); end
    checks++; if (wraps != 4) begin failures++; $display("FAIL stream_raddr_wraps got=%0d exp=4", wraps); end
    step(1'b0, 64'h0, 1'b1, 1'b1);
    checks++; if (level !== 11'd0) begin failures++; $display("FAIL stream_level_end got=%0d exp=0", level); end
  endtask

  task automatic test_full();
    int acc = 0, got = 0, bad = 0;
    logic seen = 1'b0;
    for (int c = 0; c < 1100; c++) begin
      step(1'b1, 64'h1000 + 64'(acc), 1'b0, 1'b1);
      if (!bus.in_ready) break;
      acc++;
    end
    checks++; if (acc != 1026) begin failures++; $display("FAIL full_accepted got=%0d exp=1026", acc); end
    checks++; if (level !== 11'd1026) begin failures++; $display("FAIL full_level got=%0d exp=1026", level); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h1000) begin failures++; $display("FAIL full_head got valid=%0b dat=%h exp valid=1 dat=1000", bus.out_valid, bus.out_data); end
    step(1'b1, 64'hBAD, 1'b0, 1'b1);
    step(1'b1, 64'hBAD, 1'b0, 1'b1);
    checks++; if (bus.in_ready !== 1'b0 || level !== 11'd1026) begin failures++; $display("FAIL full_settled got in_ready=%0b level=%0d exp in_ready=0 level=1026", bus.in_ready, level); end
    step(1'b0, 64'h0, 1'b1, 1'b1);  // single pop of 0x1000
    for (int c = 0; c < 2 && !seen; c++) begin
      step(1'b0, 64'h0, 1'b0, 1'b1);
      if (bus.in_ready) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL full_reready got=0 exp=1 within 2 cycles"); end
    for (int c = 0; c < 1200 && got < 1025; c++) begin
      step(1'b0, 64'h0, 1'b1, 1'b1);
      if (bus.out_valid) begin
        if (bus.out_data !== 64'h1001 + 64'(got)) bad++;
        got++;
      end
    end
    checks++; if (got != 1025 || bad != 0) begin failures++; $display("FAIL full_drain got words=%0d bad=%0d exp words=1025 bad=0", got, bad); end
    step(1'b0, 64'h0, 1'b0, 1'b1);
    checks++; if (level !== 11'd0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL full_empty got level=%0d valid=%0b exp 0/0", level, bus.out_valid); end
  endtask

  task automatic test_random();
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_d;
    int lvl_bad = 0, dat_bad = 0;
    for (int c = 0; c < 11500; c++) begin
      if (c < 10000)
        step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1);
      else if (q.size() != 0)
        step(1'b0, 64'h0, 1'b1, 1'b1);
      else
        break;
      if (level !== 11'(q.size())) begin
        if (lvl_bad == 0) $display("random first level diff: got=%0d exp=%0d cycle=%0d", level, q.size(), c);
        lvl_bad++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) dat_bad++;
        else begin
          exp_d = q.pop_front();
          if (bus.out_data !== exp_d) dat_bad++;
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
    end
    checks++; if (lvl_bad != 0) begin failures++; $display("FAIL random_level diffs got=%0d exp=0", lvl_bad); end
    checks++; if (dat_bad != 0) begin failures++; $display("FAIL random_data diffs got=%0d exp=0", dat_bad); end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL random_drain left got=%0d exp=0", q.size()); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 300; i++) step(1'b1, 64'h5000 + 64'(i), 1'b0, 1'b1);
    step(1'b0, 64'h0, 1'b1, 1'b1);  // pop: triggers a refill read
    checks++; if (level !== 11'd300 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL mid_prefill got level=%0d valid=%0b exp 300/1", level, bus.out_valid); end
    step(1'b1, 64'hDEAD, 1'b0, 1'b0);  // reset while the read is in flight
    checks++; if (bus.in_ready !== 1'b0 || ram_we !== 1'b0) begin failures++; $display("FAIL mid_rst_inputs got in_ready=%0b we=%0b exp 0/0", bus.in_ready, ram_we); end
    step(1'b0, 64'h0, 1'b0, 1'b1);
    checks++; if (bus.out_valid !== 1'b0 || level !== 11'd0 || bus.out_data !== 64'h0) begin failures++; $display("FAIL mid_after_rst got valid=%0b level=%0d dat=%h exp 0/0/0", bus.out_valid, level, bus.out_data); end
    step(1'b0, 64'h0, 1'b0, 1'b1);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale got valid=%0b exp=0", bus.out_valid); end
    step(1'b1, 64'hA5, 1'b0, 1'b1);  // cycle N
    checks++; if (ram_we !== 1'b1 || ram_waddr !== 10'd0) begin failures++; $display("FAIL mid_write got we=%0b addr=%0d exp 1/0", ram_we, ram_waddr); end
    step(1'b0, 64'h0, 1'b0, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b1);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_early got valid=%0b exp=0 at N+2", bus.out_valid); end
    step(1'b0, 64'h0, 1'b0, 1'b1);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hA5 || level !== 11'd1) begin failures++; $display("FAIL mid_a5 got valid=%0b dat=%h level=%0d exp 1/a5/1", bus.out_valid, bus.out_data, level); end
    step(1'b0, 64'h0, 1'b1, 1'b1);
    step(1'b0, 64'h0, 1'b1, 1'b1);
    checks++; if (bus.out_valid !== 1'b0 || level !== 11'd0) begin failures++; $display("FAIL mid_no_stale got valid=%0b level=%0d exp 0/0", bus.out_valid, level); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_full();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
